// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states, parity and stop-bit codes.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  localparam int unsigned MIN_DBIT = 5;

endpackage

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format, one-entry holding register for back-to-back
// frames, and break generation. Bit timing comes from an external 16x oversample tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DBIT = 9,
  parameter int unsigned SB_TICK  = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                rst,
  input  logic                s_tick,
  input  logic                tx_en,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  input  logic [MAX_DBIT-1:0] din,
  input  logic                tx_start,
  output logic                tx_ready,
  input  logic                tx_break,
  output logic                tx,
  output logic                tx_done_tick,
  output logic                tx_busy
);

  // Wide enough for the longest stop period (2 bit times).
  localparam int unsigned TW = $clog2(2 * SB_TICK);

  tx_state_e             state_q;
  logic [TW-1:0]         tick_q;
  logic [3:0]            bit_q;
  logic [MAX_DBIT-1:0]   shift_q;
  logic [MAX_DBIT-1:0]   hold_q;
  logic                  hold_full_q;
  logic [3:0]            dbits_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [1:0]            stop_q;
  logic                  mark_q;
  logic                  tx_q;
  logic                  done_q;

  logic [3:0]    dbits_c;
  logic          par_c;
  logic [TW-1:0] stop_last;
  logic          tick_end;
  logic          stop_end;
  logic          frame_go;
  logic          load;

  always_comb begin
    if (cfg_dbits < 4'(MIN_DBIT)) begin
      dbits_c = 4'(MIN_DBIT);
    end else if (cfg_dbits > 4'(MAX_DBIT)) begin
      dbits_c = 4'(MAX_DBIT);
    end else begin
      dbits_c = cfg_dbits;
    end

    par_c = (cfg_parity == PAR_ODD);
    for (int i = 0; i < int'(MAX_DBIT); i++) begin
      if (4'(i) < dbits_c) par_c = par_c ^ hold_q[i];
    end

    case (stop_q)
      STOP_1:          stop_last = TW'(SB_TICK - 1);
      STOP_1P5:        stop_last = TW'(SB_TICK * 3 / 2 - 1);
      STOP_2, 2'b11:   stop_last = TW'(2 * SB_TICK - 1);
      default:         stop_last = TW'(2 * SB_TICK - 1);
    endcase

    tick_end = s_tick && (tick_q == TW'(SB_TICK - 1));
    stop_end = s_tick && (tick_q == stop_last);
    frame_go = hold_full_q && tx_en && !tx_break;
    // A queued frame starts from IDLE, or straight out of the final stop tick.
    load     = frame_go && ((state_q == StIdle) || ((state_q == StStop) && stop_end));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dbits_q     <= 4'(MIN_DBIT);
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_q      <= STOP_1;
      mark_q      <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else if (rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dbits_q     <= 4'(MIN_DBIT);
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_q      <= STOP_1;
      mark_q      <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tx_start && !hold_full_q) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end
      if (s_tick && (state_q != StIdle)) tick_q <= tick_q + TW'(1);

      unique case (state_q)
        StIdle: begin
          if (tx_break) begin
            state_q <= StBreak;
            tx_q    <= 1'b0;
            mark_q  <= 1'b0;
            tick_q  <= '0;
          end
        end
        StStart: begin
          if (tick_end) begin
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
        end
        StData: begin
          if (tick_end) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == dbits_q - 4'd1) begin
              state_q <= par_en_q ? StParity : StStop;
              tx_q    <= par_en_q ? par_bit_q : 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (tick_end) begin
            tick_q  <= '0;
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
        StStop: begin
          if (stop_end) begin
            tick_q  <= '0;
            done_q  <= 1'b1;
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end
        end
        StBreak: begin
          // Hold the line low until release, then one bit time of mark before IDLE.
          if (!mark_q) begin
            tick_q <= '0;
            if (!tx_break) begin
              mark_q <= 1'b1;
              tx_q   <= 1'b1;
            end
          end else if (tick_end) begin
            tick_q  <= '0;
            mark_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (load) begin
        state_q     <= StStart;
        tx_q        <= 1'b0;
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        dbits_q     <= dbits_c;
        par_en_q    <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        par_bit_q   <= par_c;
        stop_q      <= cfg_stop;
        tick_q      <= '0;
        bit_q       <= '0;
      end
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != StIdle);
  assign tx_ready     = ~hold_full_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, parity, stop lengths, back-to-back, break, resets.
module tb_uart_tx_cfg;

  logic       clk;
  logic       arst_n;
  logic       rst;
  logic       s_tick;
  logic       tx_en;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic [8:0] din;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_break;
  logic       tx;
  logic       tx_done_tick;
  logic       tx_busy;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  uart_tx_cfg #(.MAX_DBIT(9), .SB_TICK(16)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_en        (tx_en),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .din          (din),
    .tx_start     (tx_start),
    .tx_ready     (tx_ready),
    .tx_break     (tx_break),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One s_tick every 4 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) if (tx_done_tick) done_cnt <= done_cnt + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic write(input logic [8:0] d);
    @(negedge clk);
    din      = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) found = 1'b1;
    end
  endtask

  // bits holds data then parity, LSB first; n is their count.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int n,
                             input int stop_ticks, input bit b2b);
    bit found;
    if (b2b) begin
      check_eq({tag, " b2b start"}, {31'b0, tx}, 0);
    end else begin
      wait_start(found);
      check_eq({tag, " start seen"}, {31'b0, found}, 1);
      if (!found) return;
    end
    wait_ticks(8);
    check_eq({tag, " start bit"}, {31'b0, tx}, 0);
    for (int k = 0; k < n; k++) begin
      wait_ticks(16);
      check_eq($sformatf("%s bit%0d", tag, k), {31'b0, tx}, {31'b0, bits[k]});
    end
    wait_ticks(16);
    check_eq({tag, " stop level"}, {31'b0, tx}, 1);
    wait_ticks(stop_ticks - 8);
    check_eq({tag, " done at stop end"}, {31'b0, tx_done_tick}, 1);
  endtask

  task automatic set_cfg(input logic [3:0] db, input logic [1:0] par, input logic [1:0] st);
    @(negedge clk);
    cfg_dbits  = db;
    cfg_parity = par;
    cfg_stop   = st;
  endtask

  int  d0;
  bit  found;

  initial begin
    arst_n = 1'b0; rst = 1'b0; tx_en = 1'b0; tx_start = 1'b0; tx_break = 1'b0;
    din = '0; cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("reset tx", {31'b0, tx}, 1);
    check_eq("reset ready", {31'b0, tx_ready}, 1);
    check_eq("reset busy", {31'b0, tx_busy}, 0);
    check_eq("reset done", {31'b0, tx_done_tick}, 0);
    arst_n = 1'b1;

    // tx_en low holds a written byte; 8N1 0x55 once enabled.
    set_cfg(4'd8, 2'b00, 2'b00);
    write(9'h055);
    repeat (100) @(negedge clk);
    check_eq("en0 busy", {31'b0, tx_busy}, 0);
    check_eq("en0 ready", {31'b0, tx_ready}, 0);
    d0 = done_cnt;
    tx_en = 1'b1;
    check_frame("8N1 55", 12'h055, 8, 16, 0);
    repeat (6) @(negedge clk);
    check_eq("8N1 busy after", {31'b0, tx_busy}, 0);
    check_eq("8N1 done count", done_cnt, d0 + 1);

    // 7E2
    set_cfg(4'd7, 2'b01, 2'b10);
    write(9'h041);
    check_frame("7E2 41", 12'h041, 8, 32, 0);
    write(9'h043);
    check_frame("7E2 43", 12'h0C3, 8, 32, 0);

    // 9O1.5
    set_cfg(4'd9, 2'b10, 2'b01);
    write(9'h1FF);
    check_frame("9O1.5 1FF", 12'h1FF, 10, 24, 0);
    write(9'h000);
    check_frame("9O1.5 000", 12'h200, 10, 24, 0);

    // cfg_dbits=2 clamps to 5; upper din bits ignored; even parity of 5 ones = 1.
    set_cfg(4'd2, 2'b01, 2'b00);
    write(9'h1FF);
    check_frame("clamp5", 12'h03F, 6, 16, 0);

    // Back-to-back with a dropped third write.
    set_cfg(4'd8, 2'b00, 2'b00);
    write(9'h0A3);
    fork
      check_frame("b2b A3", 12'h0A3, 8, 16, 0);
      begin
        repeat (2) @(negedge clk);
        write(9'h0F1);
        check_eq("b2b ready low", {31'b0, tx_ready}, 0);
        @(negedge clk);
        din = 9'h07E;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check_frame("b2b F1", 12'h0F1, 8, 16, 1);
    repeat (20) @(negedge clk);
    check_eq("b2b idle after", {31'b0, tx_busy}, 0);
    check_eq("b2b ready after", {31'b0, tx_ready}, 1);

    // Break for 5 bit periods with a byte queued during it.
    @(negedge clk);
    tx_break = 1'b1;
    @(posedge clk);
    #1;
    check_eq("brk tx low", {31'b0, tx}, 0);
    check_eq("brk busy", {31'b0, tx_busy}, 1);
    write(9'h05A);
    check_eq("brk queued", {31'b0, tx_ready}, 0);
    for (int p = 0; p < 5; p++) begin
      wait_ticks(16);
      check_eq($sformatf("brk low p%0d", p), {31'b0, tx}, 0);
    end
    @(negedge clk);
    tx_break = 1'b0;
    @(posedge clk);
    #1;
    check_eq("brk release tx", {31'b0, tx}, 1);
    wait_ticks(15);
    check_eq("brk mark", {31'b0, tx}, 1);
    check_frame("brk 5A", 12'h05A, 8, 16, 0);

    // Async reset mid-DATA with a byte queued.
    write(9'h055);
    wait_start(found);
    check_eq("arst frame start", {31'b0, found}, 1);
    write(9'h077);
    wait_ticks(40);
    d0 = done_cnt;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check_eq("arst tx", {31'b0, tx}, 1);
    check_eq("arst ready", {31'b0, tx_ready}, 1);
    check_eq("arst busy", {31'b0, tx_busy}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst no done", done_cnt, d0);
    check_eq("arst stays idle", {31'b0, tx_busy}, 0);
    write(9'h00F);
    check_frame("arst 0F", 12'h00F, 8, 16, 0);

    // Synchronous soft reset mid-DATA.
    write(9'h055);
    wait_start(found);
    check_eq("srst frame start", {31'b0, found}, 1);
    write(9'h077);
    wait_ticks(40);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("srst tx", {31'b0, tx}, 1);
    check_eq("srst ready", {31'b0, tx_ready}, 1);
    check_eq("srst busy", {31'b0, tx_busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("srst no done", done_cnt, d0);
    write(9'h033);
    check_frame("srst 33", 12'h033, 8, 16, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Next-generation UART transmitter. Frame format is runtime-configurable: 5..MAX_DBIT data bits, none/even/odd parity, and 1/1.5/2 stop bits. Adds a one-entry holding register so frames go back-to-back with no idle gap, and adds break generation. Sits between the APB register block and the tx pin, driven by the existing baud_generator s_tick (16x oversample).

Parameters:
MAX_DBIT, 9, maximum data bits; sets din width; legal range 5..9.
SB_TICK, 16, s_ticks per bit period; must be even (1.5 stop = SB_TICK*3/2).

Ports:
clk  in  1  system clock.
arst_n  in  1  asynchronous active-low reset.
rst  in  1  synchronous active-high soft reset; same effect as arst_n.
s_tick  in  1  oversample tick, one clk wide.
tx_en  in  1  transmit enable.
cfg_dbits  in  4  data bits per frame.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_stop  in  2  00 1 bit, 01 1.5 bits, 10/11 2 bits.
din  in  MAX_DBIT  data, LSB sent first; bits above cfg_dbits ignored.
tx_start  in  1  write strobe for the holding register.
tx_ready  out  1  holding register empty.
tx_break  in  1  break request.
tx  out  1  serial line, registered.
tx_done_tick  out  1  one-clk pulse when the final stop period ends.
tx_busy  out  1  state != IDLE.

Behaviour:
- Reset (arst_n low or rst high): state IDLE, tx=1, tx_ready=1, tx_done_tick=0, tx_busy=0, holding register cleared, tick and bit counters cleared. Any frame in progress is aborted; tx returns to 1 on the next clk.
- Handshake:
  - tx_start with tx_ready=1 captures din; tx_ready goes 0 on the next clk.
  - tx_start with tx_ready=0 is ignored (no overwrite).
  - tx_ready rises the clk after the holding register transfers to the shift register.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - If tx_break=1, go to BREAK (break has priority).
  - Else if holding register full and tx_en=1, go to START on the next clk (no s_tick wait).
  - Entering START does all of: load the shift register, latch cfg_dbits/cfg_parity/cfg_stop for the whole frame, set tx=0.
- Bit timing: tick counter counts s_ticks; a bit ends on the s_tick where count == SB_TICK-1.
  - START lasts SB_TICK ticks.
  - DATA lasts cfg_dbits x SB_TICK ticks, LSB first.
  - PARITY lasts SB_TICK ticks and is entered only if parity is enabled.
  - STOP (tx=1) lasts SB_TICK, 3*SB_TICK/2 or 2*SB_TICK ticks.
- cfg_dbits clamping: values <5 are treated as 5; values >MAX_DBIT are treated as MAX_DBIT.
- Parity: even = XOR of the cfg_dbits transmitted bits; odd = inverse of that.
- End of STOP: tx_done_tick=1 for that clk. Then:
  - Holding register full, tx_en=1 and tx_break=0: go directly to START (tx=0 on the next clk, zero idle bits).
  - Otherwise: go to IDLE.
- tx_en=0: no new frame starts; a frame already in progress completes normally.
- tx_break asserted mid-frame: ignored until the frame completes, then BREAK is taken from IDLE.
- BREAK:
  - tx=0 while tx_break=1 (length unbounded).
  - After deassertion, tx=1 for SB_TICK ticks (mark), then IDLE.
  - The holding register is preserved through BREAK.
- s_tick has no effect in IDLE.
- Config changes mid-frame have no effect until the next START.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE..BREAK)
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD
  - stop encodings STOP_1/STOP_1P5/STOP_2
  - MIN_DBIT=5
- No sub-module. baud_generator remains external and shared with the receiver.

Test Plan:
- 8N1, din=0x55, SB_TICK=16 -> tx: 0, 1,0,1,0,1,0,1,0, 1; each bit 16 s_ticks; tx_done_tick once; tx_busy low after.
- 7E2, din=0x41 -> 7 data bits 1000001, parity=0, stop=32 ticks; then din=0x43 -> parity=1.
- 9O1.5, din=0x1FF -> parity=0 (odd count already), stop=24 ticks; din=0x000 -> parity=1.
- Back-to-back: write 0xA3 then 0xF1 while busy -> second START immediately follows first STOP (no idle tick); third tx_start while tx_ready=0 is dropped.
- Break: tx_break high for 5 bit periods in IDLE -> tx=0 throughout, then 16 ticks of 1, then IDLE; a queued byte is sent afterwards.
- Reset mid-DATA (arst_n low, then rst high on a separate run) -> tx=1, tx_ready=1 and tx_busy=0 next clk; no tx_done_tick; the next frame is transmitted correctly.
